// File: rtl/port_tx_uart.sv
// Output-port UART transmitter: CPU writes land in a small FIFO and are
// shifted out on tx as 8N1 frames, LSB first, with occupancy and overflow status.
module port_tx_uart #(
    parameter int DEPTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               port_out,
    input  logic                     port_we,
    input  logic                     ovf_clr,
    output logic                     tx,
    output logic                     busy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CKW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [AW:0]    DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [CKW-1:0] CNT_LAST = CKW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [7:0]     shift;
    logic [2:0]     bit_idx;
    logic [CKW-1:0] clk_cnt;
    logic           push;
    logic           pop;
    logic           bit_end;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign bit_end = (clk_cnt == CNT_LAST);
    assign push    = port_we && !full;
    // The transmitter takes the head byte either from idle or on the final
    // stop-bit cycle, which is what makes consecutive frames gapless.
    assign pop     = !empty && ((state == IDLE) || (state == STOP && bit_end));

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= port_out;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (port_we && full)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            shift   <= '0;
            bit_idx <= '0;
            clk_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    clk_cnt <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_port_tx_uart.sv
// Bench for port_tx_uart: a queue-and-timer reference model predicts FIFO status
// and the byte order on the wire; an independent tx decoder scores each frame.
module tb_port_tx_uart;

    localparam int DEPTH = 4;
    localparam int C     = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    port_out;
    logic          port_we;
    logic          ovf_clr;
    logic          tx;
    logic          busy;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    port_tx_uart #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
        .clock    (clock),
        .reset    (reset),
        .port_out (port_out),
        .port_we  (port_we),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, the transmitter as a frame timer.
    byte unsigned m_q[$];
    byte unsigned exp_q[$];
    int           frame_left;
    bit           m_ovf;
    bit           was_full;
    bit           do_pop;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            frame_left = 0;
            m_ovf      = 1'b0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            do_pop   = (m_q.size() > 0) && (frame_left <= 1);
            if (port_we && was_full)
                m_ovf = 1'b1;
            else if (ovf_clr)
                m_ovf = 1'b0;
            if (do_pop) begin
                exp_q.push_back(m_q.pop_front());
                frame_left = 10 * C;
            end else if (frame_left > 0) begin
                frame_left--;
            end
            if (port_we && !was_full)
                m_q.push_back(port_out);
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            checkOutput("count", 32'(count), m_q.size());
            checkOutput("empty", empty, m_q.size() == 0);
            checkOutput("full", full, m_q.size() == DEPTH);
            checkOutput("busy", busy, frame_left > 0);
            checkOutput("overflow", overflow, m_ovf);
            if (frame_left == 0)
                checkOutput("tx_idle", tx, 1);
        end
    end

    // Line decoder: samples each bit near its centre, counted from the start edge.
    bit         mon_active = 1'b0;
    int         mon_cnt;
    logic [7:0] mon_byte;

    always @(negedge clock) begin
        if (reset) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == C / 2)
                checkOutput("start_bit", tx, 0);
            if (mon_cnt >= C + C / 2 && mon_cnt < 9 * C && (mon_cnt % C) == C / 2)
                mon_byte[mon_cnt / C - 1] = tx;
            if (mon_cnt == 9 * C + C / 2) begin
                checkOutput("stop_bit", tx, 1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL frame_unexpected: got %0h expected no frame at %0t", mon_byte, $time);
                end else begin
                    checkOutput("frame_byte", mon_byte, exp_q.pop_front());
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [7:0] data, input logic clr);
        @(negedge clock);
        port_we  = we;
        port_out = data;
        ovf_clr  = clr;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int waited = 0;
        while ((frame_left != 0 || m_q.size() != 0) && waited < 2000) begin
            idle(1);
            waited++;
        end
        if (waited >= 2000) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain_timeout: got %0d queued expected 0", m_q.size());
        end
        idle(4);
    endtask

    initial begin
        reset    = 1'b1;
        port_we  = 1'b0;
        port_out = 8'h00;
        ovf_clr  = 1'b0;
        #1;
        checkOutput("rst_tx", tx, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_overflow", overflow, 0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        idle(100);

        applyStimulus(1'b1, 8'h0A, 1'b0);
        idle(60);

        applyStimulus(1'b1, 8'h55, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0);
        idle(100);

        // Six writes: the first is taken by the transmitter, four fill, one drops.
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 8'(8'h30 + i), 1'b0);
        idle(3);
        checkOutput("ovf_set", overflow, 1);
        applyStimulus(1'b1, 8'hEE, 1'b1);
        idle(1);
        checkOutput("ovf_set_wins", overflow, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        idle(1);
        checkOutput("ovf_cleared", overflow, 0);
        drain();

        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0);
        applyStimulus(1'b1, 8'h33, 1'b0);
        begin
            int guard = 0;
            while (frame_left != 1 && guard < 200) begin
                idle(1);
                guard++;
            end
            checkOutput("sim_reached", guard < 200, 1);
        end
        checkOutput("sim_count_before", 32'(count), 2);
        applyStimulus(1'b1, 8'h44, 1'b0);
        idle(1);
        checkOutput("sim_count_after", 32'(count), 2);
        drain();

        applyStimulus(1'b1, 8'hFF, 1'b0);
        applyStimulus(1'b1, 8'hA1, 1'b0);
        applyStimulus(1'b1, 8'hB2, 1'b0);
        idle(15);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_tx", tx, 1);
        checkOutput("midrst_count", 32'(count), 0);
        checkOutput("midrst_busy", busy, 0);
        @(negedge clock);
        #2 reset = 1'b0;
        idle(100);

        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 15) == 0);
        drain();
        idle(20);
        checkOutput("frames_all_seen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
